membus_loader: RTL and testbench

- Bus initiator on the MemBus request/response protocol: the opposite end of the memory responder.
- Driven by a byte stream from the UART receive path. Executes host-issued block write/read commands against memory and returns read data plus a status byte on an output byte stream.
- Sits between the UART byte stream and a free initiator port of the memory bus arbiter. Used for program loading and memory dump without the core.

---
 rtl/membus_loader_pkg.sv | 26 ++
 rtl/loader_shift32.sv | 35 +++
 rtl/membus_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_membus_loader.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/membus_loader_pkg.sv
// Shared types and byte constants for the MemBus loader.
package membus_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_WDATA,
        S_WREQ,
        S_WWAIT,
        S_RREQ,
        S_RWAIT,
        S_RSEND,
        S_STATUS
    } loader_state_e;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ST_ACK    = 8'h06;
    localparam logic [7:0] ST_NAK    = 8'h15;

    function automatic logic [7:0] status_byte(input logic err);
        return err ? ST_NAK : ST_ACK;
    endfunction

endpackage

// File: rtl/loader_shift32.sv
// Little-endian byte shifter: bytes enter at the top and leave from the bottom,
// so four shifts assemble a LE word and repeated shifts walk a word out LSB first.
module loader_shift32 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_word,
    input  logic         shift,
    input  logic [7:0]   byte_in,
    output logic [W-1:0] shifted
);

    logic [W-1:0] word;

    generate
        if (W == 8) begin : g_narrow
            assign shifted = byte_in;
        end else begin : g_wide
            assign shifted = {byte_in, word[W-1:8]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (load) begin
            word <= load_word;
        end else if (shift) begin
            word <= shifted;
        end
    end

endmodule

// File: rtl/membus_loader.sv
// Byte-stream driven MemBus initiator: block write/read commands from the host,
// read data and a status byte returned on the output stream.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command byte
// ADDR     | collecting 4 LE address bytes
// LEN      | collecting 4 LE word-count bytes
// WDATA    | collecting DATA_BYTES LE bytes of one write word
// WREQ     | write request held until req_ready
// WWAIT    | waiting for write response or timeout
// RREQ     | read request held until req_ready
// RWAIT    | waiting for read response or timeout
// RSEND    | streaming the latched read word out LSB first
// STATUS   | presenting ACK/NAK until out_ready
module membus_loader
    import membus_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    input  logic                  req_ready,
    output logic                  req_valid,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_wen,
    output logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  resp_valid,
    input  logic [ADDR_WIDTH-1:0] resp_addr,
    input  logic                  resp_error,
    input  logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  busy
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int BC_W       = $clog2(DATA_BYTES + 4);
    localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_e         state;
    logic                  cmd_write;
    logic [BC_W-1:0]       byte_cnt;
    logic [31:0]           remaining;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  err;
    logic [TW-1:0]         tmo;

    logic                  in_fire, out_fire, req_fire, wait_done, err_next;
    logic [31:0]           rem_dec;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [31:0]           a_shifted;
    logic [DATA_WIDTH-1:0] d_shifted, d_load_word;
    logic                  a_shift, d_load, d_shift;
    logic [7:0]            d_byte_in;
    logic                  unused_resp_addr;

    assign unused_resp_addr = ^resp_addr;

    assign in_ready  = (state == S_IDLE) || (state == S_ADDR) || (state == S_LEN) || (state == S_WDATA);
    assign busy      = (state != S_IDLE);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign req_fire  = req_valid && req_ready;
    // A response on the terminal-count cycle wins over the timeout.
    assign wait_done = resp_valid || (tmo == '0);
    assign err_next  = err || (resp_valid ? resp_error : 1'b1);
    assign rem_dec   = remaining - 32'd1;
    assign addr_inc  = addr_q + ADDR_WIDTH'(DATA_BYTES);

    assign a_shift     = in_fire && ((state == S_ADDR) || (state == S_LEN));
    assign d_load      = (state == S_RWAIT) && wait_done;
    assign d_load_word = resp_valid ? resp_rdata : '0;
    assign d_shift     = (in_fire && (state == S_WDATA)) || (out_fire && (state == S_RSEND));
    assign d_byte_in   = (state == S_WDATA) ? in_data : 8'h00;

    loader_shift32 #(.W(32)) u_hdr (
        .clk       (clk),
        .reset     (reset),
        .load      (1'b0),
        .load_word (32'h0),
        .shift     (a_shift),
        .byte_in   (in_data),
        .shifted   (a_shifted)
    );

    loader_shift32 #(.W(DATA_WIDTH)) u_data (
        .clk       (clk),
        .reset     (reset),
        .load      (d_load),
        .load_word (d_load_word),
        .shift     (d_shift),
        .byte_in   (d_byte_in),
        .shifted   (d_shifted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_write <= 1'b0;
            byte_cnt  <= '0;
            remaining <= '0;
            addr_q    <= '0;
            err       <= 1'b0;
            tmo       <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            req_valid <= 1'b0;
            req_addr  <= '0;
            req_wen   <= 1'b0;
            req_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_fire) begin
                    byte_cnt <= '0;
                    if (in_data == CMD_WRITE || in_data == CMD_READ) begin
                        cmd_write <= (in_data == CMD_WRITE);
                        state     <= S_ADDR;
                    end else begin
                        out_data  <= ST_NAK;
                        out_valid <= 1'b1;
                        state     <= S_STATUS;
                    end
                end
                S_ADDR: if (in_fire) begin
                    if (byte_cnt == BC_W'(3)) begin
                        addr_q   <= ADDR_WIDTH'(a_shifted);
                        byte_cnt <= '0;
                        state    <= S_LEN;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                S_LEN: if (in_fire) begin
                    if (byte_cnt == BC_W'(3)) begin
                        byte_cnt  <= '0;
                        remaining <= a_shifted;
                        if (a_shifted == 32'd0) begin
                            out_data  <= status_byte(err);
                            out_valid <= 1'b1;
                            state     <= S_STATUS;
                        end else if (cmd_write) begin
                            state <= S_WDATA;
                        end else begin
                            req_valid <= 1'b1;
                            req_wen   <= 1'b0;
                            req_addr  <= addr_q;
                            state     <= S_RREQ;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                S_WDATA: if (in_fire) begin
                    if (byte_cnt == BC_W'(DATA_BYTES - 1)) begin
                        byte_cnt  <= '0;
                        req_valid <= 1'b1;
                        req_wen   <= 1'b1;
                        req_addr  <= addr_q;
                        req_wdata <= d_shifted;
                        state     <= S_WREQ;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                S_WREQ, S_RREQ: if (req_fire) begin
                    req_valid <= 1'b0;
                    tmo       <= TW'(TIMEOUT_CYCLES - 1);
                    state     <= (state == S_WREQ) ? S_WWAIT : S_RWAIT;
                end
                S_WWAIT: begin
                    if (wait_done) begin
                        err       <= err_next;
                        addr_q    <= addr_inc;
                        remaining <= rem_dec;
                        if (rem_dec != 32'd0) begin
                            state <= S_WDATA;
                        end else begin
                            out_data  <= status_byte(err_next);
                            out_valid <= 1'b1;
                            state     <= S_STATUS;
                        end
                    end else begin
                        tmo <= tmo - 1'b1;
                    end
                end
                S_RWAIT: begin
                    if (wait_done) begin
                        err       <= err_next;
                        addr_q    <= addr_inc;
                        remaining <= rem_dec;
                        byte_cnt  <= '0;
                        out_data  <= resp_valid ? resp_rdata[7:0] : 8'h00;
                        out_valid <= 1'b1;
                        state     <= S_RSEND;
                    end else begin
                        tmo <= tmo - 1'b1;
                    end
                end
                S_RSEND: if (out_fire) begin
                    if (byte_cnt == BC_W'(DATA_BYTES - 1)) begin
                        byte_cnt <= '0;
                        if (remaining != 32'd0) begin
                            out_valid <= 1'b0;
                            req_valid <= 1'b1;
                            req_wen   <= 1'b0;
                            req_addr  <= addr_q;
                            state     <= S_RREQ;
                        end else begin
                            out_data <= status_byte(err);
                            state    <= S_STATUS;
                        end
                    end else begin
                        out_data <= d_shifted[7:0];
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                S_STATUS: if (out_fire) begin
                    out_valid <= 1'b0;
                    err       <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_membus_loader.sv
// Directed bench for membus_loader with a behavioural MemBus responder.
module tb_membus_loader;

    localparam int BOUND = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_data, out_data;
    logic        req_ready, req_valid, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_addr, resp_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_in_cyc = 0;

    // responder controls (written by the test) and observations (written by the responder)
    int  resp_enable = 1, resp_delay = 0, err_fire = -1;
    int  stall_cycles = 0, stall_req = 0, force_req = 0;
    int  fire_cnt = 0, stall_seen = 0, stall_bad = 0;
    logic [31:0] log_addr[$], log_wdata[$];
    logic        log_wen[$];
    int          fire_cyc_q[$];
    logic [31:0] mem [0:15];

    membus_loader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .req_ready(req_ready), .req_valid(req_valid), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_error(resp_error),
        .resp_rdata(resp_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int          pend_cnt, stall_left, force_done, stall_done;
        logic        fired, pending, pend_wen, pend_err, stall_chk;
        logic [31:0] cap_addr, cap_wdata, pend_addr, pend_wdata, snap_addr, snap_wdata;
        logic        cap_wen, snap_wen;
        fired = 0; pending = 0; stall_chk = 0; stall_left = 0; force_done = 0; stall_done = 0;
        pend_cnt = 0; cap_wen = 0; pend_wen = 0; pend_err = 0; snap_wen = 0;
        cap_addr = 0; cap_wdata = 0; pend_addr = 0; pend_wdata = 0; snap_addr = 0; snap_wdata = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[2] = 32'hC0FFEE01;
        req_ready = 0; resp_valid = 0; resp_error = 0; resp_addr = 0; resp_rdata = 0;
        forever begin
            @(negedge clk);
            resp_valid = 0; resp_error = 0; resp_rdata = 0;
            if (fired) begin
                fired = 0;
                fire_cnt++;
                fire_cyc_q.push_back(cyc);
                log_addr.push_back(cap_addr); log_wen.push_back(cap_wen); log_wdata.push_back(cap_wdata);
                if (resp_enable != 0) begin
                    pending = 1; pend_cnt = resp_delay; pend_addr = cap_addr;
                    pend_wen = cap_wen; pend_wdata = cap_wdata; pend_err = (err_fire == fire_cnt);
                end
            end
            if (pending) begin
                if (pend_cnt == 0) begin
                    pending = 0; resp_valid = 1; resp_addr = pend_addr; resp_error = pend_err;
                    if (pend_wen) mem[pend_addr[5:2]] = pend_wdata;
                    else resp_rdata = mem[pend_addr[5:2]];
                end else begin
                    pend_cnt--;
                end
            end
            if (force_done != force_req) begin
                force_done = force_req; resp_valid = 1; resp_rdata = 32'hDEADBEEF; resp_error = 1;
            end
            if (req_valid === 1'b1 && reset === 1'b0) begin
                if (stall_done != stall_req) begin
                    stall_done = stall_req; stall_left = stall_cycles; stall_chk = 1;
                    snap_addr = req_addr; snap_wdata = req_wdata; snap_wen = req_wen;
                end
                if (stall_left > 0) begin
                    stall_left--; stall_seen++; req_ready = 0;
                    if (req_addr !== snap_addr || req_wdata !== snap_wdata || req_wen !== snap_wen) stall_bad++;
                end else begin
                    req_ready = 1;
                end
            end else begin
                req_ready = 0;
            end
            if (req_valid === 1'b1 && req_ready === 1'b1) begin
                fired = 1; cap_addr = req_addr; cap_wen = req_wen; cap_wdata = req_wdata;
                if (stall_chk) begin
                    if (req_addr !== snap_addr || req_wdata !== snap_wdata || req_wen !== snap_wen) stall_bad++;
                    stall_chk = 0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1; in_data = b;
        while (in_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) begin
            checks++; errors++;
            $display("FAIL send_byte_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        last_in_cyc = cyc;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] n);
        send_byte(c); send_word(a); send_word(n);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) begin
            checks++; errors++;
            $display("FAIL recv_byte_wait: out_valid=%b after %0d cycles, required 1", out_valid, n);
            b = 8'hxx;
        end else begin
            b = out_data;
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 0; in_data = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, req_valid, req_wen, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: {in_ready,out_valid,req_valid,req_wen,busy}=%b, required 10000",
                     {in_ready, out_valid, req_valid, req_wen, busy});
        end
        checks++;
        if (req_addr !== 32'h0 || req_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: req_addr=%h req_wdata=%h, required 0/0", req_addr, req_wdata);
        end
    endtask

    task automatic test_write();
        logic [7:0] got;
        int base, t4;
        base = log_addr.size();
        send_cmd(8'h57, 32'h00001000, 32'd2);
        send_word(32'h44332211);
        t4 = last_in_cyc;
        send_word(32'h88776655);
        recv_byte(got);
        checks++;
        if (got !== 8'h06) begin errors++; $display("FAIL write_status: got %h, required 06", got); end
        checks++;
        if (log_addr.size() != base + 2) begin
            errors++; $display("FAIL write_fires: got %0d, required 2", log_addr.size() - base);
        end else begin
            checks++;
            if (log_addr[base] !== 32'h1000 || log_wdata[base] !== 32'h44332211 || log_wen[base] !== 1'b1) begin
                errors++;
                $display("FAIL write_req0: addr=%h wdata=%h wen=%b, required 1000/44332211/1",
                         log_addr[base], log_wdata[base], log_wen[base]);
            end
            checks++;
            if (log_addr[base+1] !== 32'h1004 || log_wdata[base+1] !== 32'h88776655 || log_wen[base+1] !== 1'b1) begin
                errors++;
                $display("FAIL write_req1: addr=%h wdata=%h wen=%b, required 1004/88776655/1",
                         log_addr[base+1], log_wdata[base+1], log_wen[base+1]);
            end
            checks++;
            if (fire_cyc_q[base] != t4 + 1) begin
                errors++;
                $display("FAIL write_latency: fire %0d cycles after last byte, required 1", fire_cyc_q[base] - t4);
            end
        end
    endtask

    task automatic test_read();
        logic [7:0] exp [8];
        logic [7:0] got;
        int base, n;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        base = log_addr.size();
        send_cmd(8'h52, 32'h00001000, 32'd2);
        n = 0;
        while (out_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h11) begin
                errors++;
                $display("FAIL read_hold: out_valid=%b out_data=%h, required 1/11", out_valid, out_data);
            end
        end
        for (int i = 0; i < 8; i++) begin
            recv_byte(got);
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL read_byte%0d: got %h, required %h", i, got, exp[i]); end
        end
        recv_byte(got);
        checks++;
        if (got !== 8'h06) begin errors++; $display("FAIL read_status: got %h, required 06", got); end
        checks++;
        if (log_addr.size() != base + 2 || log_wen[base] !== 1'b0 || log_wen[base+1] !== 1'b0 ||
            log_addr[base] !== 32'h1000 || log_addr[base+1] !== 32'h1004) begin
            errors++;
            $display("FAIL read_reqs: fires=%0d, required 2 reads at 1000/1004 with wen=0", log_addr.size() - base);
        end
    endtask

    task automatic test_stall();
        logic [7:0] got;
        int base, seen0;
        base = log_addr.size(); seen0 = stall_seen;
        stall_cycles = 5; stall_req++;
        send_cmd(8'h57, 32'h00002010, 32'd1);
        send_word(32'hDDCCBBAA);
        recv_byte(got);
        checks++;
        if (got !== 8'h06) begin errors++; $display("FAIL stall_status: got %h, required 06", got); end
        checks++;
        if (stall_seen - seen0 != 5 || stall_bad != 0) begin
            errors++;
            $display("FAIL stall_hold: stall cycles=%0d unstable=%0d, required 5/0", stall_seen - seen0, stall_bad);
        end
        checks++;
        if (log_addr.size() != base + 1 || log_addr[base] !== 32'h2010 || log_wdata[base] !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL stall_fire: fires=%0d, required one write of DDCCBBAA at 2010", log_addr.size() - base);
        end
        stall_cycles = 0;
    endtask

    task automatic test_resp_error();
        logic [7:0] exp [12];
        logic [7:0] got;
        int base;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h01, 8'hEE, 8'hFF, 8'hC0};
        err_fire = fire_cnt + 1;
        send_cmd(8'h52, 32'h00001000, 32'd3);
        for (int i = 0; i < 12; i++) begin
            recv_byte(got);
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL rerr_byte%0d: got %h, required %h", i, got, exp[i]); end
        end
        recv_byte(got);
        checks++;
        if (got !== 8'h15) begin errors++; $display("FAIL rerr_status: got %h, required 15", got); end
        err_fire = -1;
        base = log_addr.size();
        send_cmd(8'h57, 32'h00000000, 32'd0);
        recv_byte(got);
        checks++;
        if (got !== 8'h06) begin errors++; $display("FAIL count0_status: got %h, required 06", got); end
        repeat (3) @(negedge clk);
        checks++;
        if (log_addr.size() != base) begin
            errors++; $display("FAIL count0_bus: fires=%0d, required 0", log_addr.size() - base);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] got;
        int base, n;
        resp_enable = 0;
        base = log_addr.size();
        send_cmd(8'h52, 32'h00001008, 32'd1);
        n = 0;
        while (out_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        checks++;
        if (log_addr.size() != base + 1 || cyc - fire_cyc_q[base] != 16) begin
            errors++;
            $display("FAIL timeout_cycles: first byte %0d cycles after fire, required 16", cyc - fire_cyc_q[base]);
        end
        for (int i = 0; i < 4; i++) begin
            recv_byte(got);
            checks++;
            if (got !== 8'h00) begin errors++; $display("FAIL timeout_byte%0d: got %h, required 00", i, got); end
        end
        recv_byte(got);
        checks++;
        if (got !== 8'h15) begin errors++; $display("FAIL timeout_status: got %h, required 15", got); end
        resp_enable = 1;
        force_req++;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, out_valid, req_valid, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL late_resp: {busy,out_valid,req_valid,in_ready}=%b, required 0001",
                     {busy, out_valid, req_valid, in_ready});
        end
    endtask

    task automatic test_timeout_boundary();
        logic [7:0] exp [4];
        logic [7:0] got;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        resp_delay = 15;
        send_cmd(8'h52, 32'h00001000, 32'd1);
        for (int i = 0; i < 4; i++) begin
            recv_byte(got);
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL edge_resp_byte%0d: got %h, required %h", i, got, exp[i]); end
        end
        recv_byte(got);
        checks++;
        if (got !== 8'h06) begin errors++; $display("FAIL edge_resp_status: got %h, required 06", got); end
        resp_delay = 16;
        send_cmd(8'h52, 32'h00001004, 32'd1);
        for (int i = 0; i < 4; i++) begin
            recv_byte(got);
            checks++;
            if (got !== 8'h00) begin errors++; $display("FAIL edge_tmo_byte%0d: got %h, required 00", i, got); end
        end
        recv_byte(got);
        checks++;
        if (got !== 8'h15) begin errors++; $display("FAIL edge_tmo_status: got %h, required 15", got); end
        resp_delay = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_bad_cmd();
        logic [7:0] got;
        send_byte(8'h41);
        recv_byte(got);
        checks++;
        if (got !== 8'h15) begin errors++; $display("FAIL badcmd_status: got %h, required 15", got); end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL badcmd_idle: busy=%b in_ready=%b, required 0/1", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        int f0, n;
        resp_delay = 6;
        f0 = fire_cnt;
        send_cmd(8'h52, 32'h00001000, 32'd1);
        n = 0;
        while (fire_cnt == f0 && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) begin checks++; errors++; $display("FAIL rst_mid_fire: no fire seen, required 1"); end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        checks++;
        if ({in_ready, out_valid, req_valid, req_wen, busy} !== 5'b10000 || req_addr !== 32'h0 || req_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ctrl=%b addr=%h wdata=%h, required 10000/0/0",
                     {in_ready, out_valid, req_valid, req_wen, busy}, req_addr, req_wdata);
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({busy, out_valid, req_valid} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_late: {busy,out_valid,req_valid}=%b, required 000", {busy, out_valid, req_valid});
        end
        resp_delay = 0;
        send_cmd(8'h52, 32'h00000000, 32'd0);
        recv_byte(got);
        checks++;
        if (got !== 8'h06) begin errors++; $display("FAIL rst_mid_next: got %h, required 06", got); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_resp_error();
        test_timeout();
        test_timeout_boundary();
        test_bad_cmd();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
